calc_core: RTL and testbench
============================

CALC_CORE -- requirements
Module: calc_core

Interface
REQ-001 DIGITS, default 2, max decimal digits per operand (1..4).
REQ-002 OUT_DIGITS, default 2*DIGITS, result/display digit count (derived, not overridden).
REQ-003 clk  in  1  single system clock; all logic rising-edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 key_valid  in  1  one-cycle pulse; key_code valid this cycle.
REQ-006 key_code  in  4  0-9 digit, a '+', b '-', c '*', d '/', e '=', f clear.
REQ-007 disp_bcd  out  4*OUT_DIGITS  BCD digits, digit 0 = LSD.
REQ-008 disp_en  out  OUT_DIGITS  per-digit enable; leading zeros blanked, digit 0 always on.
REQ-009 disp_neg  out  1  minus sign for negative result.
REQ-010 busy  out  1  high in CALC/CONV; keys other than clear ignored.
REQ-011 result_valid  out  1  one-cycle pulse on entry to SHOW.
REQ-012 err  out  1  high in ERR state.

Function
REQ-013 States: IDLE, A_ENT, OP, B_ENT, CALC, CONV, SHOW, ERR.
REQ-014 IDLE: digit -> A = digit, A_ENT; other keys ignored.
REQ-015 A_ENT: digit with count<DIGITS -> A = A*10+digit; digit at count=DIGITS ignored; op key -> latch op, OP; '=' ignored.
REQ-016 OP: digit -> B = digit, B_ENT; another op key replaces latched op.
REQ-017 B_ENT: digits as A_ENT into B; '=' -> CALC; op keys ignored.
REQ-018 CALC: '+','-','*' complete in 1 cycle; '/' by iterative restoring divider, one quotient bit per cycle, latency = operand bit width; B=0 with '/' -> ERR.
REQ-019 '-': A<B -> magnitude B-A, neg flag set; integer quotient, remainder discarded.
REQ-020 CONV: binary-to-BCD by sequential shift-add-3, one bit per cycle; then SHOW.
REQ-021 SHOW: result displayed; digit key -> new A, A_ENT; op key -> result becomes A (only if neg=0, else ignored), OP.
REQ-022 Clear (f) in any state, including busy -> IDLE next cycle, operands/result/neg zeroed, divider/converter aborted.
REQ-023 ERR: disp_bcd shows 0xE in digit 0, disp_en=1 for digit 0 only; only clear exits.
REQ-024 Entry display: A_ENT/OP show A, B_ENT shows B, IDLE shows 0; disp_neg=0 outside SHOW.
REQ-025 key_valid with key_code outside table or in busy (non-clear): no state change.
REQ-026 Operand width = ceil(log2(10^DIGITS)); result width = 2x operand width; no overflow possible.

Reset
REQ-027 On rst: state IDLE, A=B=result=0, disp_bcd=0, disp_en=1 (digit 0 only), disp_neg=0, busy=0, result_valid=0, err=0.
REQ-028 rst asserted mid-CALC/CONV aborts; first key after release treated as from IDLE.

Configuration
REQ-029 Macro CALC_DIV_EN: defined -> divider compiled, '/' per REQ-018.
REQ-030 Undefined -> no divider logic; '/' key ignored in every state; div-by-zero ERR path absent.

Structure
REQ-031 Package calc_pkg: key code constants, state encoding (one-hot), width functions from DIGITS.
REQ-032 Sub-module calc_bin2bcd (sequential converter, start/done handshake) instantiated once.

Verification
REQ-033 Keys 1,2,'+',3,4,'=' -> result_valid after CONV; disp_bcd=0x0046, disp_en=0011.
REQ-034 Keys 5,'-',1,2,'=' -> disp_bcd digits 07, disp_neg=1.
REQ-035 DIGITS=2, keys 9,9,'*',9,9,'=' -> 9801, all four digits enabled.
REQ-036 CALC_DIV_EN: 9,9,'/',0,'=' -> err=1, digit0=E; clear -> IDLE, err=0; 9,9,'/',7,'=' -> 14.
REQ-037 Clear pulsed during divider busy -> busy=0 next cycle, display 0, no result_valid.
REQ-038 Keys 1,2,3 with DIGITS=2 -> A=12 (third digit ignored); rst mid-entry -> all outputs at reset values.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calc_core keypad calculator: key codes, one-hot
// state encoding, operator type and operand/result width helpers.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'ha;
    localparam logic [3:0] KEY_SUB = 4'hb;
    localparam logic [3:0] KEY_MUL = 4'hc;
    localparam logic [3:0] KEY_DIV = 4'hd;
    localparam logic [3:0] KEY_EQ  = 4'he;
    localparam logic [3:0] KEY_CLR = 4'hf;

    typedef enum logic [7:0] {
        S_IDLE  = 8'h01,
        S_A_ENT = 8'h02,
        S_OP    = 8'h04,
        S_B_ENT = 8'h08,
        S_CALC  = 8'h10,
        S_CONV  = 8'h20,
        S_SHOW  = 8'h40,
        S_ERR   = 8'h80
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    function automatic int pow10(input int d);
        int p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    function automatic int op_width(input int d);
        return $clog2(pow10(d));
    endfunction

    function automatic int res_width(input int d);
        return 2 * op_width(d);
    endfunction

    // Operator keys a..d map onto consecutive op_t values.
    function automatic op_t key_to_op(input logic [3:0] k);
        return op_t'(2'(k - KEY_ADD));
    endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per cycle.
// start loads a new value, done pulses once the BCD output is final, abort clears.
module calc_bin2bcd #(
    parameter int NB = 14,
    parameter int ND = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [NB-1:0]   bin,
    output logic [4*ND-1:0] bcd,
    output logic            done
);

    localparam int CW = $clog2(NB + 1);

    logic [NB-1:0]   sh;
    logic [CW-1:0]   cnt;
    logic            run;
    logic [4*ND-1:0] adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < ND; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh   <= '0;
            bcd  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else if (abort) begin
            sh   <= '0;
            bcd  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sh  <= bin;
                bcd <= '0;
                cnt <= CW'(NB);
                run <= 1'b1;
            end else if (run) begin
                // Results never exceed ND digits, so dropping the top BCD bit is lossless.
                bcd <= (4*ND)'({adj, sh[NB-1]});
                sh  <= sh << 1;
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/calc_core.sv
// calc_core: keypad-driven four-function decimal calculator with BCD display.
// Define CALC_DIV_EN to build the '/' restoring divider; without it '/' is ignored.
module calc_core
    import calc_pkg::*;
#(
    parameter  int DIGITS     = 2,
    localparam int OUT_DIGITS = 2 * DIGITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    output logic [4*OUT_DIGITS-1:0] disp_bcd,
    output logic [OUT_DIGITS-1:0]   disp_en,
    output logic                    disp_neg,
    output logic                    busy,
    output logic                    result_valid,
    output logic                    err
);

    localparam int OW    = op_width(DIGITS);
    localparam int RW    = res_width(DIGITS);
    localparam int BW    = 4 * DIGITS;
    localparam int DW    = 4 * OUT_DIGITS;
    localparam int LIMIT = pow10(DIGITS);

    state_t        state, state_nx;
    op_t           op;
    logic [OW-1:0] a, b, dig, a_app, b_app;
    logic [BW-1:0] a_bcd, b_bcd;
    logic [2:0]    cnt;
    logic [RW-1:0] result;
    logic          neg;
    logic          conv_start, conv_done;
    logic [DW-1:0] conv_bcd, shown;
    logic          nz_seen;
    logic          is_clr, is_dig, is_op, is_eq, can_add, fits;

    assign is_clr  = key_valid && key_code == KEY_CLR;
    assign is_dig  = key_valid && key_code <= 4'd9;
    assign is_eq   = key_valid && key_code == KEY_EQ;
`ifdef CALC_DIV_EN
    assign is_op   = key_valid && key_code >= KEY_ADD && key_code <= KEY_DIV;
`else
    assign is_op   = key_valid && key_code >= KEY_ADD && key_code <= KEY_MUL;
`endif
    assign can_add = cnt < 3'(DIGITS);
    // A result may only be chained as the next A if it fits the operand range.
    assign fits    = result < RW'(LIMIT);
    assign dig     = OW'(key_code);
    assign a_app   = a * OW'(10) + dig;
    assign b_app   = b * OW'(10) + dig;

`ifdef CALC_DIV_EN
    localparam int DCW = $clog2(OW + 1);
    logic [OW-1:0]  dq, rem;
    logic [OW:0]    rem_sh, rem_diff;
    logic [DCW-1:0] div_cnt;
    logic           div_last, q_bit;

    assign rem_sh   = {rem, dq[OW-1]};
    assign rem_diff = rem_sh - {1'b0, b};
    assign q_bit    = ~rem_diff[OW];
    assign div_last = div_cnt == DCW'(1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            conv_start   <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            // NOTE: registers use <= so every flop samples pre-edge values in the same cycle.
            state        <= state_nx;
            conv_start   <= state == S_CALC && state_nx == S_CONV;
            result_valid <= state == S_CONV && state_nx == S_SHOW;
        end
    end

    always_comb begin
        // NOTE: default first, so no branch leaves state_nx unassigned and infers a latch.
        state_nx = state;
        if (is_clr) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (is_dig) state_nx = S_A_ENT;
                S_A_ENT: if (is_op) state_nx = S_OP;
                S_OP:    if (is_dig) state_nx = S_B_ENT;
                S_B_ENT: if (is_eq) state_nx = S_CALC;
                S_CALC: begin
`ifdef CALC_DIV_EN
                    if (op == OP_DIV) begin
                        if (b == '0) state_nx = S_ERR;
                        else if (div_last) state_nx = S_CONV;
                    end else
`endif
                    state_nx = S_CONV;
                end
                S_CONV:  if (conv_done) state_nx = S_SHOW;
                S_SHOW: begin
                    if (is_dig) state_nx = S_A_ENT;
                    else if (is_op && !neg && fits) state_nx = S_OP;
                end
                S_ERR:   state_nx = S_ERR;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a <= '0; b <= '0; a_bcd <= '0; b_bcd <= '0; cnt <= '0;
            result <= '0; neg <= 1'b0; op <= OP_ADD;
`ifdef CALC_DIV_EN
            dq <= '0; rem <= '0; div_cnt <= '0;
`endif
        end else if (is_clr) begin
            a <= '0; b <= '0; a_bcd <= '0; b_bcd <= '0; cnt <= '0;
            result <= '0; neg <= 1'b0; op <= OP_ADD;
`ifdef CALC_DIV_EN
            dq <= '0; rem <= '0; div_cnt <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (is_dig) begin
                    a <= dig; a_bcd <= BW'(key_code); cnt <= 3'd1;
                end
                S_A_ENT: begin
                    if (is_dig && can_add) begin
                        a <= a_app; a_bcd <= BW'({a_bcd, key_code}); cnt <= cnt + 1'b1;
                    end else if (is_op) begin
                        op <= key_to_op(key_code);
                    end
                end
                S_OP: begin
                    if (is_dig) begin
                        b <= dig; b_bcd <= BW'(key_code); cnt <= 3'd1;
                    end else if (is_op) begin
                        op <= key_to_op(key_code);
                    end
                end
                S_B_ENT: begin
                    if (is_dig && can_add) begin
                        b <= b_app; b_bcd <= BW'({b_bcd, key_code}); cnt <= cnt + 1'b1;
                    end
`ifdef CALC_DIV_EN
                    else if (is_eq) begin
                        dq <= a; rem <= '0; div_cnt <= DCW'(OW);
                    end
`endif
                end
                S_CALC: begin
                    case (op)
                        OP_ADD: begin result <= RW'(a) + RW'(b); neg <= 1'b0; end
                        OP_SUB: begin
                            neg    <= a < b;
                            result <= (a < b) ? RW'(b - a) : RW'(a - b);
                        end
                        OP_MUL: begin result <= RW'(a) * RW'(b); neg <= 1'b0; end
                        default: begin
`ifdef CALC_DIV_EN
                            neg <= 1'b0;
                            if (b != '0) begin
                                dq      <= {dq[OW-2:0], q_bit};
                                rem     <= q_bit ? rem_diff[OW-1:0] : rem_sh[OW-1:0];
                                div_cnt <= div_cnt - 1'b1;
                                if (div_last) result <= RW'({dq[OW-2:0], q_bit});
                            end
`endif
                        end
                    endcase
                end
                S_SHOW: begin
                    if (is_dig) begin
                        a <= dig; a_bcd <= BW'(key_code); cnt <= 3'd1; neg <= 1'b0;
                    end else if (is_op && !neg && fits) begin
                        a <= OW'(result); a_bcd <= conv_bcd[BW-1:0];
                        op <= key_to_op(key_code);
                    end
                end
                default: ;
            endcase
        end
    end

    calc_bin2bcd #(
        .NB(RW),
        .ND(OUT_DIGITS)
    ) u_bin2bcd (
        .clk  (clk),
        .rst  (rst),
        .start(conv_start),
        .abort(is_clr),
        .bin  (result),
        .bcd  (conv_bcd),
        .done (conv_done)
    );

    always_comb begin
        case (state)
            S_A_ENT, S_OP:           shown = DW'(a_bcd);
            S_B_ENT, S_CALC, S_CONV: shown = DW'(b_bcd);
            S_SHOW:                  shown = conv_bcd;
            S_ERR:                   shown = DW'(4'hE);
            default:                 shown = '0;
        endcase
        nz_seen = 1'b0;
        disp_en = '0;
        for (int i = OUT_DIGITS - 1; i >= 0; i--) begin
            nz_seen    = nz_seen | (shown[4*i +: 4] != 4'd0);
            disp_en[i] = nz_seen || i == 0;
        end
    end

    assign disp_bcd = shown;
    assign disp_neg = state == S_SHOW && neg;
    assign busy     = state == S_CALC || state == S_CONV;
    assign err      = state == S_ERR;

endmodule

// File: tb/tb_calc_core.sv
// Randomized self-checking bench for calc_core (DIGITS=2) against an
// integer-arithmetic calculator model; honours CALC_DIV_EN when defined.
module tb_calc_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] disp_bcd;
    logic [3:0]  disp_en;
    logic        disp_neg, busy, result_valid, err;

    calc_core dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .disp_bcd    (disp_bcd),
        .disp_en     (disp_en),
        .disp_neg    (disp_neg),
        .busy        (busy),
        .result_valid(result_valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

`ifdef CALC_DIV_EN
    localparam int MAX_OP = 13;
`else
    localparam int MAX_OP = 12;
`endif

    typedef enum {M_IDLE, M_A, M_OP, M_B, M_BUSY, M_SHOW, M_ERR} mode_t;
    mode_t mode;
    int    ma, mb, mcnt, mop, mres;
    bit    mneg, pend_err;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] en_of(input int v);
        logic [3:0] e;
        e = 4'b0001;
        if (v >= 10)   e[1] = 1'b1;
        if (v >= 100)  e[2] = 1'b1;
        if (v >= 1000) e[3] = 1'b1;
        return e;
    endfunction

    task automatic model_reset();
        mode = M_IDLE; ma = 0; mb = 0; mcnt = 0; mop = 10; mres = 0; mneg = 0; pend_err = 0;
    endtask

    task automatic model_key(input int k);
        bit is_d, is_o;
        is_d = k <= 9;
        is_o = k >= 10 && k <= MAX_OP;
        if (k == 15) begin
            model_reset();
            return;
        end
        case (mode)
            M_IDLE: if (is_d) begin ma = k; mcnt = 1; mode = M_A; end
            M_A: begin
                if (is_d && mcnt < 2) begin ma = ma * 10 + k; mcnt++; end
                else if (is_o) begin mop = k; mode = M_OP; end
            end
            M_OP: begin
                if (is_d) begin mb = k; mcnt = 1; mode = M_B; end
                else if (is_o) mop = k;
            end
            M_B: begin
                if (is_d && mcnt < 2) begin mb = mb * 10 + k; mcnt++; end
                else if (k == 14) begin
                    mode = M_BUSY; mneg = 0; pend_err = 0;
                    case (mop)
                        10: mres = ma + mb;
                        11: if (ma < mb) begin mres = mb - ma; mneg = 1; end else mres = ma - mb;
                        12: mres = ma * mb;
                        default: if (mb == 0) pend_err = 1; else mres = ma / mb;
                    endcase
                end
            end
            M_SHOW: begin
                if (is_d) begin ma = k; mcnt = 1; mneg = 0; mode = M_A; end
                else if (is_o && !mneg && mres < 100) begin ma = mres; mop = k; mode = M_OP; end
            end
            default: ;
        endcase
    endtask

    task automatic press_raw(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        int v;
        logic [15:0] eb;
        logic [3:0]  ee;
        case (mode)
            M_A, M_OP: v = ma;
            M_B:       v = mb;
            M_SHOW:    v = mres;
            default:   v = 0;
        endcase
        eb = to_bcd(v);
        ee = en_of(v);
        if (mode == M_ERR) begin eb = 16'h000E; ee = 4'b0001; end
        check({tag, ":bcd"}, 32'(disp_bcd), 32'(eb));
        check({tag, ":en"},  32'(disp_en),  32'(ee));
        check({tag, ":neg"}, 32'(disp_neg), 32'(mode == M_SHOW && mneg));
        check({tag, ":err"}, 32'(err),      32'(mode == M_ERR));
        check({tag, ":busy"}, 32'(busy),    32'd0);
    endtask

    // Waits out CALC/CONV, sprinkling ignored keys, until the result or error appears.
    task automatic wait_result(input string tag);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        check({tag, ":busy_eq"}, 32'(busy), 32'd1);
        while (!done && n < 300) begin
            @(negedge clk);
            key_valid = 1'b0;
            n++;
            if (result_valid || err) done = 1;
            else if ($urandom_range(0, 3) == 0) begin
                key_valid = 1'b1;
                key_code  = 4'($urandom_range(0, 14));
            end
        end
        key_valid = 1'b0;
        check({tag, ":timeout"}, 32'(done), 32'd1);
        if (pend_err) begin
            check({tag, ":err_entry"}, 32'(err), 32'd1);
            mode = M_ERR;
        end else begin
            check({tag, ":rv_high"}, 32'(result_valid), 32'd1);
            mode = M_SHOW;
            @(negedge clk);
            check({tag, ":rv_pulse"}, 32'(result_valid), 32'd0);
        end
    endtask

    task automatic key(input logic [3:0] k, input string tag);
        press_raw(k);
        model_key(int'(k));
        if (mode == M_BUSY) wait_result(tag);
        check_outputs(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":bcd"},  32'(disp_bcd),     32'h0);
        check({tag, ":en"},   32'(disp_en),      32'h1);
        check({tag, ":neg"},  32'(disp_neg),     32'h0);
        check({tag, ":busy"}, 32'(busy),         32'h0);
        check({tag, ":rv"},   32'(result_valid), 32'h0);
        check({tag, ":err"},  32'(err),          32'h0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r;
        bit rv_seen;
        rst = 1'b1;
        key_valid = 1'b0;
        key_code = 4'h0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        key(4'h1, "add"); key(4'h2, "add"); key(4'ha, "add");
        key(4'h3, "add"); key(4'h4, "add"); key(4'he, "add");
        check("add46:bcd", 32'(disp_bcd), 32'h0046);
        check("add46:en",  32'(disp_en),  32'b0011);
        key(4'hf, "clr");

        key(4'h5, "sub"); key(4'hb, "sub"); key(4'h1, "sub"); key(4'h2, "sub"); key(4'he, "sub");
        check("sub07:bcd", 32'(disp_bcd), 32'h0007);
        check("sub07:neg", 32'(disp_neg), 32'd1);
        key(4'ha, "sub_neg_op_ignored");
        key(4'hf, "clr");

        key(4'h9, "mul"); key(4'h9, "mul"); key(4'hc, "mul");
        key(4'h9, "mul"); key(4'h9, "mul"); key(4'he, "mul");
        check("mul9801:bcd", 32'(disp_bcd), 32'h9801);
        check("mul9801:en",  32'(disp_en),  32'b1111);
        key(4'ha, "mul_big_op_ignored");
        key(4'hf, "clr");

        key(4'h3, "chain"); key(4'ha, "chain"); key(4'h4, "chain"); key(4'he, "chain");
        key(4'hc, "chain"); key(4'h6, "chain"); key(4'he, "chain");
        check("chain42:bcd", 32'(disp_bcd), 32'h0042);
        key(4'hf, "clr");

`ifdef CALC_DIV_EN
        key(4'h9, "div0"); key(4'h9, "div0"); key(4'hd, "div0"); key(4'h0, "div0"); key(4'he, "div0");
        check("div0:err",   32'(err),      32'd1);
        check("div0:digit", 32'(disp_bcd), 32'h000E);
        key(4'h5, "err_sticky");
        key(4'hf, "div0_clr");
        check("div0_clr:err", 32'(err), 32'd0);
        key(4'h9, "div"); key(4'h9, "div"); key(4'hd, "div"); key(4'h7, "div"); key(4'he, "div");
        check("div14:bcd", 32'(disp_bcd), 32'h0014);
        key(4'hf, "clr");
`else
        key(4'h9, "nodiv"); key(4'h9, "nodiv"); key(4'hd, "nodiv");
        check("nodiv:bcd", 32'(disp_bcd), 32'h0099);
        key(4'hf, "clr");
`endif

        key(4'h9, "abort"); key(4'h9, "abort"); key(4'(MAX_OP), "abort"); key(4'h7, "abort");
        press_raw(4'he);
        check("abort:busy_eq", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        press_raw(4'hf);
        model_reset();
        check("abort:busy", 32'(busy), 32'd0);
        check_outputs("abort");
        rv_seen = 0;
        repeat (60) begin
            @(negedge clk);
            rv_seen |= result_valid;
        end
        check("abort:no_rv", 32'(rv_seen), 32'd0);

        key(4'h1, "ent3"); key(4'h2, "ent3"); key(4'h3, "ent3");
        check("ent3:bcd", 32'(disp_bcd), 32'h0012);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        key(4'h4, "after_rst");

        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      key(4'($urandom_range(0, 9)), "rnd");
            else if (r < 80) key(4'($urandom_range(10, 13)), "rnd");
            else if (r < 93) key(4'he, "rnd");
            else             key(4'hf, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
